// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: decodes the branch direction and computes the
// redirect target. It registers the result one cycle later, flagging a
// mispredict when the direction differs from the fetch prediction. It keeps
// a BHT of 2-bit saturating counters, read at fetch and trained at
// resolution, and counts accepted branches and mispredicts with saturation.
module branch_resolve_unit #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AWIDTH-1:0]    pred_pc_i,
    output logic                 pred_taken_o,
    input  logic                 res_valid_i,
    input  logic [AWIDTH-1:0]    res_pc_i,
    input  logic [2:0]           res_funct3_i,
    input  logic [DWIDTH-1:0]    res_rs1_i,
    input  logic [DWIDTH-1:0]    res_rs2_i,
    input  logic [DWIDTH-1:0]    res_imm_i,
    input  logic                 res_pred_taken_i,
    input  logic                 flush_i,
    output logic                 res_valid_o,
    output logic                 res_taken_o,
    output logic                 res_mispredict_o,
    output logic [AWIDTH-1:0]    res_target_o,
    output logic                 res_illegal_o,
    output logic [CNT_WIDTH-1:0] br_count_o,
    output logic [CNT_WIDTH-1:0] mispred_count_o
);

    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    logic [1:0]        bht_q [BHT_ENTRIES];
    logic [IdxW-1:0]   pred_idx;
    logic [IdxW-1:0]   res_idx;
    logic [1:0]        bht_cur;
    logic [1:0]        bht_nxt;
    logic              eq;
    logic              lt_s;
    logic              lt_u;
    logic              taken;
    logic              illegal;
    logic              accept;
    logic              train;
    logic              mispredict;
    logic [AWIDTH-1:0] imm_a;
    logic [AWIDTH-1:0] target;

    // PC bits outside the BHT index play no part in prediction.
    logic unused_pred_pc;
    assign unused_pred_pc = ^{pred_pc_i[AWIDTH-1:IdxW+2], pred_pc_i[1:0]};

    assign pred_idx     = pred_pc_i[IdxW+1:2];
    assign res_idx      = res_pc_i[IdxW+1:2];
    // Read returns the stored value; a same-cycle update lands on the edge.
    assign pred_taken_o = bht_q[pred_idx][1];

    // Fit the immediate to the PC width (truncate or sign-extend).
    generate
        if (DWIDTH >= AWIDTH) begin : g_imm_trunc
            assign imm_a = res_imm_i[AWIDTH-1:0];
        end else begin : g_imm_sext
            assign imm_a = {{(AWIDTH-DWIDTH){res_imm_i[DWIDTH-1]}}, res_imm_i};
        end
    endgenerate

    // Direction decode from funct3 and the operand comparisons.
    always_comb begin
        eq      = (res_rs1_i == res_rs2_i);
        lt_s    = ($signed(res_rs1_i) < $signed(res_rs2_i));
        lt_u    = (res_rs1_i < res_rs2_i);
        taken   = 1'b0;
        illegal = 1'b0;
        case (res_funct3_i)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = !lt_u;
            default: illegal = 1'b1;
        endcase
    end

    assign target     = res_pc_i + (taken ? imm_a : AWIDTH'(4));
    assign accept     = res_valid_i && !flush_i;
    assign train      = accept && !illegal;
    assign mispredict = !illegal && (taken != res_pred_taken_i);

    // Saturating counter step for the entry being resolved.
    always_comb begin
        bht_cur = bht_q[res_idx];
        bht_nxt = bht_cur;
        if (taken) begin
            if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
        end
    end

    // Registered resolution result; payload holds while nothing is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid_o      <= 1'b0;
            res_taken_o      <= 1'b0;
            res_mispredict_o <= 1'b0;
            res_target_o     <= '0;
            res_illegal_o    <= 1'b0;
        end else begin
            res_valid_o <= accept;
            if (accept) begin
                res_taken_o      <= taken;
                res_mispredict_o <= mispredict;
                res_target_o     <= target;
                res_illegal_o    <= illegal;
            end
        end
    end

    // BHT storage, trained only by accepted legal branches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (train) begin
            bht_q[res_idx] <= bht_nxt;
        end
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else if (train) begin
            if (br_count_o != '1) br_count_o <= br_count_o + 1'b1;
            if (mispredict && (mispred_count_o != '1)) begin
                mispred_count_o <= mispred_count_o + 1'b1;
            end
        end
    end

endmodule
